// File: rtl/sram_arbiter_controller_pkg.sv
// Shared types and constants for the multi-port asynchronous SRAM controller.
package sram_arbiter_controller_pkg;

    localparam int unsigned DEFAULT_SRAM_WAIT_CYCLES = 1;
    localparam int unsigned DEFAULT_ADDR_WIDTH       = 20;
    localparam int unsigned DEFAULT_DATA_WIDTH       = 32;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0]   Ram_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0]   Word_t;
    typedef logic                            Bit_t;
    typedef logic [DEFAULT_DATA_WIDTH/8-1:0] Byte_mask_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} Sram_state_t;

    // Index width that stays at least one bit for a single-entry selector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_arbiter_controller_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant, wrapping.
module rr_arbiter
    import sram_arbiter_controller_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] grant,
    output logic          any_req
);

    logic [IW-1:0] idx;

    // Walk from lowest to highest priority so the nearest requester overwrites the rest.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            idx = IW'((32'(last_grant) + k) % N);
            if (req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter_controller.sv
// Round-robin arbitration of several bus masters onto one asynchronous SRAM,
// with configurable strobe hold time and per-port byte masks.
module sram_arbiter_controller
    import sram_arbiter_controller_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ADDR_WIDTH  = 20,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned WAIT_CYCLES = DEFAULT_SRAM_WAIT_CYCLES
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] bus_addr,
    input  logic [NUM_PORTS-1:0]                 read_op,
    input  logic [NUM_PORTS-1:0]                 write_op,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] bus_data_write,
    input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]   byte_mask,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] bus_data_read,
    output logic [NUM_PORTS-1:0]                 bus_stall,
    inout  wire  [DATA_WIDTH-1:0]                ram_data,
    output logic [ADDR_WIDTH-1:0]                ram_addr,
    output logic [BE_WIDTH-1:0]                  ram_be_n,
    output logic                                 ram_ce_n,
    output logic                                 ram_oe_n,
    output logic                                 ram_we_n
);

    localparam int unsigned IW = idx_width(NUM_PORTS);

    Sram_state_t          state;
    logic [3:0]           cnt;
    logic [IW-1:0]        grant;
    logic [IW-1:0]        last_grant;
    logic [DATA_WIDTH-1:0] wdata;
    Bit_t                 is_write;
    Bit_t                 drive;

    logic [NUM_PORTS-1:0] req;
    logic [IW-1:0]        arb_grant;
    logic                 arb_any;

    assign req = read_op | write_op;

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any_req    (arb_any)
    );

    always_comb begin
        bus_stall = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            bus_stall[i] = req[i] & ~((state == DONE) && (grant == IW'(i)));
        end
    end

    // Write data stays on the bus through DONE to give the SRAM data hold after WE rises.
    assign ram_data = drive ? wdata : 'z;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            grant         <= '0;
            last_grant    <= IW'(NUM_PORTS - 1);
            wdata         <= '0;
            is_write      <= 1'b0;
            drive         <= 1'b0;
            bus_data_read <= '0;
            ram_addr      <= '0;
            ram_be_n      <= '1;
            ram_ce_n      <= 1'b1;
            ram_oe_n      <= 1'b1;
            ram_we_n      <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    drive <= 1'b0;
                    if (arb_any) begin
                        grant    <= arb_grant;
                        is_write <= write_op[arb_grant];
                        wdata    <= bus_data_write[arb_grant];
                        ram_addr <= bus_addr[arb_grant];
                        ram_ce_n <= 1'b0;
                        cnt      <= '0;
                        state    <= ACCESS;
                        if (write_op[arb_grant]) begin
                            ram_we_n <= 1'b0;
                            ram_be_n <= ~byte_mask[arb_grant];
                            drive    <= 1'b1;
                        end else begin
                            ram_oe_n <= 1'b0;
                            ram_be_n <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'(WAIT_CYCLES)) begin
                        ram_ce_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        ram_be_n <= '1;
                        if (!is_write) begin
                            bus_data_read[grant] <= ram_data;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    last_grant <= grant;
                    drive      <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter_controller.sv
// Self-checking bench: vector table with a completion scoreboard, plus contention,
// mid-access reset and alternate wait-state builds.
module tb_sram_arbiter_controller;
    import sram_arbiter_controller_pkg::*;

    localparam int unsigned NP = 2;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NP-1:0][AW-1:0] bus_addr;
    logic [NP-1:0]         read_op;
    logic [NP-1:0]         write_op;
    logic [NP-1:0][DW-1:0] bus_data_write;
    logic [NP-1:0][BW-1:0] byte_mask;
    logic [NP-1:0][DW-1:0] bus_data_read;
    logic [NP-1:0]         bus_stall;
    wire  [DW-1:0]         ram_data;
    logic [AW-1:0]         ram_addr;
    logic [BW-1:0]         ram_be_n;
    logic                  ram_ce_n, ram_oe_n, ram_we_n;

    sram_arbiter_controller #(
        .NUM_PORTS (NP), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .WAIT_CYCLES (1)
    ) dut (
        .clk (clk), .rst (rst), .bus_addr (bus_addr), .read_op (read_op),
        .write_op (write_op), .bus_data_write (bus_data_write), .byte_mask (byte_mask),
        .bus_data_read (bus_data_read), .bus_stall (bus_stall), .ram_data (ram_data),
        .ram_addr (ram_addr), .ram_be_n (ram_be_n), .ram_ce_n (ram_ce_n),
        .ram_oe_n (ram_oe_n), .ram_we_n (ram_we_n)
    );

    // Fake asynchronous SRAM for the main instance.
    Word_t mem [256];
    assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] : 'z;
    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n) begin
            for (int b = 0; b < BW; b++) begin
                if (!ram_be_n[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
            end
        end
    end

    // Two extra builds with different wait states share one stimulus set.
    logic [NP-1:0][AW-1:0] s_addr;
    logic [NP-1:0]         s_rd;
    logic [NP-1:0]         s_zero_op;
    logic [NP-1:0][DW-1:0] s_zero_data;
    logic [NP-1:0][BW-1:0] s_zero_mask;
    logic [NP-1:0][DW-1:0] w0_rd, w3_rd;
    logic [NP-1:0]         w0_stall, w3_stall;
    wire  [DW-1:0]         w0_data, w3_data;
    logic [AW-1:0]         w0_addr, w3_addr;
    logic [BW-1:0]         w0_be_n, w3_be_n;
    logic                  w0_ce_n, w0_oe_n, w0_we_n, w3_ce_n, w3_oe_n, w3_we_n;

    sram_arbiter_controller #(.NUM_PORTS (NP), .WAIT_CYCLES (0)) dut_w0 (
        .clk (clk), .rst (rst), .bus_addr (s_addr), .read_op (s_rd), .write_op (s_zero_op),
        .bus_data_write (s_zero_data), .byte_mask (s_zero_mask), .bus_data_read (w0_rd),
        .bus_stall (w0_stall), .ram_data (w0_data), .ram_addr (w0_addr), .ram_be_n (w0_be_n),
        .ram_ce_n (w0_ce_n), .ram_oe_n (w0_oe_n), .ram_we_n (w0_we_n)
    );
    sram_arbiter_controller #(.NUM_PORTS (NP), .WAIT_CYCLES (3)) dut_w3 (
        .clk (clk), .rst (rst), .bus_addr (s_addr), .read_op (s_rd), .write_op (s_zero_op),
        .bus_data_write (s_zero_data), .byte_mask (s_zero_mask), .bus_data_read (w3_rd),
        .bus_stall (w3_stall), .ram_data (w3_data), .ram_addr (w3_addr), .ram_be_n (w3_be_n),
        .ram_ce_n (w3_ce_n), .ram_oe_n (w3_oe_n), .ram_we_n (w3_we_n)
    );
    assign w0_data = (!w0_ce_n && !w0_oe_n) ? (32'hC0DE_0000 | 32'(w0_addr)) : 'z;
    assign w3_data = (!w3_ce_n && !w3_oe_n) ? (32'hC0DE_0000 | 32'(w3_addr)) : 'z;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    bit   sb_on = 1'b0;

    // Completion scoreboard: a requesting port that is not stalled has just finished.
    always @(negedge clk) begin
        if (sb_on) begin
            for (int p = 0; p < NP; p++) begin
                if ((read_op[p] | write_op[p]) && !bus_stall[p]) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected actual=port%0d required=none", p);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_port", 32'(p), 32'(e.port));
                        if (e.is_read) check("sb_rdata", bus_data_read[p], e.data);
                    end
                end
            end
        end
    end

    int          we_cnt = 0;
    logic [3:0]  we_be  = 4'hF;
    int          stall_run [NP];
    int          stall_max = 0;
    always @(negedge clk) begin
        if (!ram_we_n) begin
            we_cnt++;
            we_be = ram_be_n;
        end
        for (int p = 0; p < NP; p++) begin
            if (bus_stall[p]) begin
                stall_run[p]++;
                if (stall_run[p] > stall_max) stall_max = stall_run[p];
            end else begin
                stall_run[p] = 0;
            end
        end
    end

    // Drive one request in the IDLE cycle and count stalled cycles until completion.
    task automatic do_access(input int p, input bit rd, input bit wr, input logic [19:0] a,
                             input logic [31:0] d, input logic [3:0] m, output int n);
        @(posedge clk);
        #1;
        read_op        = '0;
        write_op       = '0;
        bus_addr[p]    = a;
        bus_data_write[p] = d;
        byte_mask[p]   = m;
        read_op[p]     = rd;
        write_op[p]    = wr;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus_stall[p]) break;
            n++;
            if (n > 40) begin
                total++;
                bad++;
                $display("FAIL access_timeout actual=%0d required<=40", n);
                break;
            end
        end
    endtask

    typedef struct {
        int          port;
        bit          rd;
        bit          wr;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp;
        int          exp_we;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] exp_last [NP];

    initial begin
        int n;
        int c0;
        int c3;
        int cyc;

        vecs[0] = '{0, 1'b0, 1'b1, 20'h10, 32'hDEADBEEF, 4'hF, 32'h0,        2, 4'h0};
        vecs[1] = '{0, 1'b1, 1'b0, 20'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0, 4'hF};
        vecs[2] = '{1, 1'b0, 1'b1, 20'h20, 32'h11223344, 4'hF, 32'h0,        2, 4'h0};
        vecs[3] = '{1, 1'b0, 1'b1, 20'h20, 32'hAABBCCDD, 4'h3, 32'h0,        2, 4'hC};
        vecs[4] = '{1, 1'b1, 1'b0, 20'h20, 32'h0,        4'h0, 32'h1122CCDD, 0, 4'hF};
        vecs[5] = '{0, 1'b1, 1'b1, 20'h30, 32'h0000FFFF, 4'hF, 32'h0,        2, 4'h0};
        vecs[6] = '{0, 1'b1, 1'b0, 20'h30, 32'h0,        4'h0, 32'h0000FFFF, 0, 4'hF};
        vecs[7] = '{1, 1'b0, 1'b1, 20'h30, 32'h12345678, 4'h0, 32'h0,        2, 4'hF};
        vecs[8] = '{1, 1'b1, 1'b0, 20'h30, 32'h0,        4'h0, 32'h0000FFFF, 0, 4'hF};
        vecs[9] = '{0, 1'b1, 1'b0, 20'h20, 32'h0,        4'h0, 32'h1122CCDD, 0, 4'hF};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int p = 0; p < NP; p++) begin
            stall_run[p] = 0;
            exp_last[p]  = '0;
        end
        bus_addr = '0; read_op = '0; write_op = '0; bus_data_write = '0; byte_mask = '0;
        s_addr = '0; s_rd = '0; s_zero_op = '0; s_zero_data = '0; s_zero_mask = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ce_n", 32'(ram_ce_n), 32'd1);
        check("rst_oe_n", 32'(ram_oe_n), 32'd1);
        check("rst_we_n", 32'(ram_we_n), 32'd1);
        check("rst_be_n", 32'(ram_be_n), 32'hF);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_rd0", bus_data_read[0], 32'd0);
        check("rst_rd1", bus_data_read[1], 32'd0);
        check("rst_stall", 32'(bus_stall), 32'd0);

        // Completion cycle for WAIT_CYCLES=0 and 3 builds (cycle 1 is the IDLE request cycle).
        @(posedge clk);
        #1;
        s_addr[0] = 20'h5;
        s_rd[0]   = 1'b1;
        c0 = 0;
        c3 = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c0 == 0 && !w0_stall[0]) c0 = c;
            if (c3 == 0 && !w3_stall[0]) c3 = c;
        end
        check("w0_done_cycle", 32'(c0), 32'd3);
        check("w3_done_cycle", 32'(c3), 32'd6);
        check("w0_rdata", w0_rd[0], 32'hC0DE0005);
        check("w3_rdata", w3_rd[0], 32'hC0DE0005);
        @(posedge clk);
        #1;
        s_rd = '0;

        sb_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e.port    = vecs[i].port;
            e.is_read = vecs[i].rd && !vecs[i].wr;
            e.data    = vecs[i].exp;
            sb.push_back(e);
            if (e.is_read) exp_last[vecs[i].port] = vecs[i].exp;
            we_cnt = 0;
            do_access(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].mask, n);
            #1;
            check("stall_cycles", 32'(n), 32'd3);
            check("sb_drained", 32'(sb.size()), 32'd0);
            check("we_cycles", 32'(we_cnt), 32'(vecs[i].exp_we));
            if (vecs[i].wr) check("write_be_n", 32'(we_be), 32'(vecs[i].exp_be));
            for (int q = 0; q < NP; q++) check("rdata_hold", bus_data_read[q], exp_last[q]);
        end
        sb_on = 1'b0;

        // Both ports read continuously from reset: grants must alternate starting at port 0.
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus_addr[0] = 20'h10;
        bus_addr[1] = 20'h20;
        read_op  = 2'b11;
        write_op = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.port    = k % 2;
            e.is_read = 1'b1;
            e.data    = (k % 2 == 0) ? 32'hDEADBEEF : 32'h1122CCDD;
            sb.push_back(e);
        end
        stall_max = 0;
        for (int p = 0; p < NP; p++) stall_run[p] = 0;
        sb_on = 1'b1;
        cyc = 0;
        while (sb.size() > 0 && cyc < 80) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("rr_all_served", 32'(sb.size()), 32'd0);
        check("rr_no_starve", 32'(stall_max <= 8), 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        sb_on   = 1'b0;
        read_op = '0;

        // Reset in the second ACCESS cycle of a port-1 read aborts the access.
        do_access(1, 1'b1, 1'b0, 20'h20, 32'h0, 4'h0, n);
        check("pre_rst_rd1", bus_data_read[1], 32'h1122CCDD);
        @(posedge clk);
        #1;
        read_op     = '0;
        bus_addr[1] = 20'h10;
        read_op[1]  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("access2_oe_n", 32'(ram_oe_n), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ce_n", 32'(ram_ce_n), 32'd1);
        check("abort_oe_n", 32'(ram_oe_n), 32'd1);
        check("abort_we_n", 32'(ram_we_n), 32'd1);
        check("abort_be_n", 32'(ram_be_n), 32'hF);
        check("abort_rd1", bus_data_read[1], 32'd0);
        rst     = 1'b0;
        read_op = '0;
        do_access(0, 1'b1, 1'b0, 20'h10, 32'h0, 4'h0, n);
        check("post_rst_stall", 32'(n), 32'd3);
        check("post_rst_rd0", bus_data_read[0], 32'hDEADBEEF);
        check("post_rst_rd1", bus_data_read[1], 32'd0);
        @(posedge clk);
        #1;
        read_op = '0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter_controller.md
Name: sram_arbiter_controller

Overview:
- Parametrised successor to the single-master SRAM controller.
- Arbitrates NUM_PORTS independent bus masters (e.g. IF and MEM stages) onto one asynchronous SRAM chip.
- Access timing is configurable (WAIT_CYCLES); byte masks are honoured per port.
- Sits between the CPU bus ports and the top-level SRAM pins; in simulation it connects to fake_sram.

Parameters:
- NUM_PORTS, 2, number of bus master ports.
- ADDR_WIDTH, 20, SRAM word address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- WAIT_CYCLES, 1, extra strobe-hold cycles per access (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- bus_addr  in  [NUM_PORTS][ADDR_WIDTH]  per-port word address.
- read_op  in  [NUM_PORTS]  per-port read request.
- write_op  in  [NUM_PORTS]  per-port write request.
- bus_data_write  in  [NUM_PORTS][DATA_WIDTH]  per-port write data.
- byte_mask  in  [NUM_PORTS][BE_WIDTH]  per-port write byte enables, active-high.
- bus_data_read  out  [NUM_PORTS][DATA_WIDTH]  per-port read data, registered.
- bus_stall  out  [NUM_PORTS]  per-port stall, combinational.
- ram_data  inout  DATA_WIDTH  SRAM data bus.
- ram_addr  out  ADDR_WIDTH  SRAM address.
- ram_be_n  out  BE_WIDTH  SRAM byte enables, active-low.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset values: state IDLE; ram_ce_n/oe_n/we_n = 1; ram_be_n = all 1; ram_addr = 0; ram_data high-Z; bus_data_read all 0; last_grant = NUM_PORTS-1, so port 0 wins first.
- Request: port i requests when read_op[i] | write_op[i]. Masters must hold request, address, data and mask stable while bus_stall[i] = 1.
- Stall: bus_stall[i] = request[i] & !(state == DONE && grant == i). A port with no request never stalls.
- IDLE:
  - If any port requests, grant the first requesting port searching from last_grant+1 with wrap (round-robin).
  - Latch addr/data/mask/direction into registers and go to ACCESS with cnt = 0.
  - If both read_op and write_op are set, the access is a write.
- ACCESS:
  - Drive ram_addr and ram_ce_n = 0.
  - Read: ram_oe_n = 0, ram_be_n = 0, ram_data high-Z.
  - Write: ram_we_n = 0, ram_data driven, ram_be_n = ~mask.
  - Stay WAIT_CYCLES+1 cycles (cnt counts to WAIT_CYCLES).
  - On the final ACCESS edge a read captures ram_data into bus_data_read[grant]; then go to DONE.
- DONE:
  - All strobes = 1.
  - For a write, ram_data stays driven for data hold; for a read it is high-Z.
  - bus_stall[grant] = 0 this cycle; update last_grant = grant; go to IDLE.
- Latency: request seen in IDLE → stall held WAIT_CYCLES+2 cycles → completes in cycle WAIT_CYCLES+3. Back-to-back accesses from one port have a 1-cycle IDLE gap.
- bus_data_read[i] holds its value until the next read completion for port i. Other ports' values are never disturbed.
- A write with byte_mask = 0 still runs a full cycle with ram_be_n all 1; memory is unchanged and the access completes normally.
- A request withdrawn mid-access: the SRAM cycle still finishes; a withdrawn write still writes; a read result is still stored.
- rst during ACCESS/DONE: abort; at the next edge strobes = 1, data high-Z, and no bus_data_read update. A partial write at the SRAM is acceptable.
- A request arriving while another port is being served waits; it is never starved, and is served within NUM_PORTS accesses.

Decomposition:
- Shared package: Ram_addr_t, Word_t, Bit_t, Byte_mask_t typedefs; enum Sram_state_t {IDLE, ACCESS, DONE}; constant DEFAULT_SRAM_WAIT_CYCLES.
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req[N], last_grant.
  - Outputs: grant index, any_req. Purely combinational.

Test Plan:
- Port 0 write addr 0x00010 data 0xDEADBEEF mask 4'b1111, then read the same address (WAIT_CYCLES=1) → read returns 0xDEADBEEF; each access stalls exactly 3 cycles; ram_we_n is low for exactly 2 cycles.
- Preload 0x11223344; port 1 write 0xAABBCCDD mask 4'b0011, then read → 0x1122CCDD; ram_be_n = 4'b1100 during the write.
- Ports 0 and 1 both read every cycle, continuously, from reset → grants alternate 0,1,0,1; neither bus_stall stays high beyond 2×(WAIT_CYCLES+3) cycles.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds, single read → completion in cycle 3 and cycle 6 respectively.
- rst asserted in the 2nd ACCESS cycle of a read on port 1 → next cycle all strobes = 1, state IDLE, bus_data_read[1] = 0.
- Port 0 asserts read_op and write_op with data 0x0000FFFF → a write is performed; a subsequent read returns 0x0000FFFF.
